// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - side-info types, field widths, frame lengths and region defaults
// Shared by side_info_parser and bit_extractor: side_info_t layout, the parse
// field sequence (field_t), per-field bit widths and the implicit region counts.
package mp3_pkg;

    localparam int BUF_BITS           = 256;
    localparam int FIELD_W            = 12;
    localparam int FRAME_BYTES_MONO   = 17;
    localparam int FRAME_BYTES_STEREO = 32;

    localparam int W_MDB         = 9;
    localparam int W_PRIV_MONO   = 5;
    localparam int W_PRIV_STEREO = 3;
    localparam int W_SCFSI       = 4;
    localparam int W_P23         = 12;
    localparam int W_BV          = 9;
    localparam int W_GG          = 8;
    localparam int W_SFC         = 4;
    localparam int W_BT          = 2;
    localparam int W_TS          = 5;
    localparam int W_SG          = 3;
    localparam int W_R0          = 4;
    localparam int W_R1          = 3;

    // Implicit region counts for window-switched granules.
    localparam logic [3:0] REGION0_LONG  = 4'd7;
    localparam logic [3:0] REGION0_SHORT = 4'd8;
    localparam logic [3:0] REGION1_SHORT = 4'd12;
    localparam logic [3:0] REGION1_LONG  = 4'd13;

    typedef struct packed {
        logic [11:0]     part2_3_length;
        logic [8:0]      big_values;
        logic [7:0]      global_gain;
        logic [3:0]      scalefac_compress;
        logic            window_switching_flag;
        logic [1:0]      block_type;
        logic            mixed_block_flag;
        logic [2:0][4:0] table_select;
        logic [2:0][2:0] subblock_gain;
        logic [3:0]      region0_count;
        logic [3:0]      region1_count;    // 4 bits: implicit values 12/13 exceed the 3-bit field
        logic            preflag;
        logic            scalefac_scale;
        logic            count1table_select;
    } gr_ch_t;

    typedef struct packed {
        logic [8:0]         main_data_begin;
        logic [4:0]         private_bits;
        logic [1:0][3:0]    scfsi;          // [channel]
        gr_ch_t [1:0][1:0]  gc;             // [granule][channel]
    } side_info_t;

    typedef enum logic [4:0] {
        F_MDB, F_PRIV, F_SCFSI,
        F_P23, F_BV, F_GG, F_SFC, F_WSF,
        F_BT, F_MIX, F_TS0, F_TS1, F_TS2,
        F_SG0, F_SG1, F_SG2, F_R0, F_R1,
        F_PRE, F_SFS, F_C1
    } field_t;

    function automatic logic [3:0] field_width(input field_t f, input logic single);
        logic [3:0] w;
        case (f)
            F_MDB:                   w = 4'(W_MDB);
            F_PRIV:                  w = single ? 4'(W_PRIV_MONO) : 4'(W_PRIV_STEREO);
            F_SCFSI:                 w = 4'(W_SCFSI);
            F_P23:                   w = 4'(W_P23);
            F_BV:                    w = 4'(W_BV);
            F_GG:                    w = 4'(W_GG);
            F_SFC:                   w = 4'(W_SFC);
            F_BT:                    w = 4'(W_BT);
            F_TS0, F_TS1, F_TS2:     w = 4'(W_TS);
            F_SG0, F_SG1, F_SG2:     w = 4'(W_SG);
            F_R0:                    w = 4'(W_R0);
            F_R1:                    w = 4'(W_R1);
            default:                 w = 4'd1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bit_extractor.sv
// rtl/bit_extractor.sv - combinational right-aligned field read from the frame buffer
// Ports: buffer  - 256-bit frame, bit 255 is the first stream bit
//        bit_ptr - stream offset of the field's first (MSB) bit
//        width   - field width, 1..12
//        field   - field value, right-aligned and zero-extended
module bit_extractor
    import mp3_pkg::*;
(
    input  logic [BUF_BITS-1:0] buffer,
    input  logic [7:0]          bit_ptr,
    input  logic [3:0]          width,
    output logic [FIELD_W-1:0]  field
);

    // Discard the bits before the pointer, then drop everything after the field.
    assign field = FIELD_W'((buffer << bit_ptr) >> (BUF_BITS - 32'(width)));

endmodule

// File: rtl/side_info_parser.sv
// rtl/side_info_parser.sv - MP3 layer-III side-info byte collector and field parser
// Ports: clk, rst (sync, active-high)
//        frame_start - restart collection; mono sampled with it
//        axiid/axiiv - side-info bytes, MSB first
//        busy        - collecting or parsing
//        axiov       - one-cycle pulse, si holds a complete decoded frame
//        overrun     - one-cycle pulse, a byte arrived while parsing and was dropped
//        err         - sticky reserved block_type flag (SIDE_INFO_CHECK_EN), else 0
//        si          - decoded side info, updated only with axiov
// Optional feature macro: SIDE_INFO_CHECK_EN
module side_info_parser
    import mp3_pkg::*;
#(
    parameter int MAX_CH    = 2,
    parameter int PARSE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       mono,
    input  logic [7:0] axiid,
    input  logic       axiiv,
    output logic       busy,
    output logic       axiov,
    output logic       overrun,
    output logic       err,
    output side_info_t si
);

    localparam int GAP_W = (PARSE_GAP > 0) ? $clog2(PARSE_GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, PARSE, DONE} state_t;

    state_t              state, state_d;
    logic [31:0][7:0]    buf_bytes;     // byte 0 of the frame sits in buf_bytes[31]
    logic [4:0]          byte_cnt;
    logic                single;        // one decoded channel: mono frame or MAX_CH==1
    logic                last_ch;
    field_t              fid, fid_d;
    logic                gr, ch, gr_d, ch_d;
    logic [7:0]          bit_ptr;
    logic [GAP_W-1:0]    gap_cnt;
    side_info_t          sh, sh_d;
    logic [3:0]          width;
    logic [FIELD_W-1:0]  field_val;
    logic                step, last_byte, parse_end;
`ifdef SIDE_INFO_CHECK_EN
    logic                err_set;
    logic                err_q;
`endif

    assign last_ch   = ~single;
    assign step      = (gap_cnt == '0);
    assign last_byte = axiiv && (byte_cnt == (single ? 5'(FRAME_BYTES_MONO - 1)
                                                     : 5'(FRAME_BYTES_STEREO - 1)));
    assign parse_end = step && (fid == F_C1) && gr && (ch == last_ch);
    assign width     = field_width(fid, single);

    bit_extractor u_bit_extractor (
        .buffer  (buf_bytes),
        .bit_ptr (bit_ptr),
        .width   (width),
        .field   (field_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        axiov   = 1'b0;
        case (state)
            IDLE: ;
            COLLECT: begin
                busy = 1'b1;
                if (last_byte) state_d = PARSE;
            end
            PARSE: begin
                busy = 1'b1;
                if (parse_end) state_d = DONE;
            end
            DONE: begin
                axiov   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new frame overrides everything, including a parse about to complete.
        if (frame_start) state_d = COLLECT;
    end

    // Field walk: decode the current field into the shadow and pick the next one.
    always_comb begin
        sh_d  = sh;
        fid_d = fid;
        gr_d  = gr;
        ch_d  = ch;
`ifdef SIDE_INFO_CHECK_EN
        err_set = 1'b0;
`endif
        case (fid)
            F_MDB: begin
                sh_d.main_data_begin = field_val[8:0];
                fid_d = F_PRIV;
            end
            F_PRIV: begin
                sh_d.private_bits = field_val[4:0];
                fid_d = F_SCFSI;
            end
            F_SCFSI: begin
                sh_d.scfsi[ch] = field_val[3:0];
                if (ch == last_ch) begin
                    ch_d  = 1'b0;
                    fid_d = F_P23;
                end else begin
                    ch_d = 1'b1;
                end
            end
            F_P23: begin
                sh_d.gc[gr][ch].part2_3_length = field_val;
                fid_d = F_BV;
            end
            F_BV: begin
                sh_d.gc[gr][ch].big_values = field_val[8:0];
                fid_d = F_GG;
            end
            F_GG: begin
                sh_d.gc[gr][ch].global_gain = field_val[7:0];
                fid_d = F_SFC;
            end
            F_SFC: begin
                sh_d.gc[gr][ch].scalefac_compress = field_val[3:0];
                fid_d = F_WSF;
            end
            F_WSF: begin
                // Preload every field that one of the two layouts leaves implicit.
                sh_d.gc[gr][ch].window_switching_flag = field_val[0];
                sh_d.gc[gr][ch].block_type            = 2'd0;
                sh_d.gc[gr][ch].mixed_block_flag      = 1'b0;
                sh_d.gc[gr][ch].table_select[2]       = 5'd0;
                sh_d.gc[gr][ch].subblock_gain         = '0;
                sh_d.gc[gr][ch].region0_count         = field_val[0] ? REGION0_LONG : 4'd0;
                sh_d.gc[gr][ch].region1_count         = field_val[0] ? REGION1_LONG : 4'd0;
                fid_d = field_val[0] ? F_BT : F_TS0;
            end
            F_BT: begin
                sh_d.gc[gr][ch].block_type = field_val[1:0];
`ifdef SIDE_INFO_CHECK_EN
                err_set = (field_val[1:0] == 2'd0);
`endif
                fid_d = F_MIX;
            end
            F_MIX: begin
                sh_d.gc[gr][ch].mixed_block_flag = field_val[0];
                if (sh.gc[gr][ch].block_type == 2'd2 && !field_val[0]) begin
                    sh_d.gc[gr][ch].region0_count = REGION0_SHORT;
                    sh_d.gc[gr][ch].region1_count = REGION1_SHORT;
                end
                fid_d = F_TS0;
            end
            F_TS0: begin
                sh_d.gc[gr][ch].table_select[0] = field_val[4:0];
                fid_d = F_TS1;
            end
            F_TS1: begin
                sh_d.gc[gr][ch].table_select[1] = field_val[4:0];
                fid_d = sh.gc[gr][ch].window_switching_flag ? F_SG0 : F_TS2;
            end
            F_TS2: begin
                sh_d.gc[gr][ch].table_select[2] = field_val[4:0];
                fid_d = F_R0;
            end
            F_SG0: begin
                sh_d.gc[gr][ch].subblock_gain[0] = field_val[2:0];
                fid_d = F_SG1;
            end
            F_SG1: begin
                sh_d.gc[gr][ch].subblock_gain[1] = field_val[2:0];
                fid_d = F_SG2;
            end
            F_SG2: begin
                sh_d.gc[gr][ch].subblock_gain[2] = field_val[2:0];
                fid_d = F_PRE;
            end
            F_R0: begin
                sh_d.gc[gr][ch].region0_count = field_val[3:0];
                fid_d = F_R1;
            end
            F_R1: begin
                sh_d.gc[gr][ch].region1_count = {1'b0, field_val[2:0]};
                fid_d = F_PRE;
            end
            F_PRE: begin
                sh_d.gc[gr][ch].preflag = field_val[0];
                fid_d = F_SFS;
            end
            F_SFS: begin
                sh_d.gc[gr][ch].scalefac_scale = field_val[0];
                fid_d = F_C1;
            end
            F_C1: begin
                sh_d.gc[gr][ch].count1table_select = field_val[0];
                fid_d = F_P23;
                if (ch == last_ch) begin
                    ch_d = 1'b0;
                    gr_d = 1'b1;
                end else begin
                    ch_d = 1'b1;
                end
            end
            default: fid_d = F_MDB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_bytes <= '0;
            byte_cnt  <= 5'd0;
            single    <= 1'b0;
            fid       <= F_MDB;
            gr        <= 1'b0;
            ch        <= 1'b0;
            bit_ptr   <= 8'd0;
            gap_cnt   <= '0;
            sh        <= '0;
            si        <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_start) begin
                single <= mono || (MAX_CH == 1);
                // Cleared shadow leaves the channel-1 slots zero for single-channel frames.
                sh     <= '0;
                if (axiiv) begin
                    buf_bytes[31] <= axiid;
                    byte_cnt      <= 5'd1;
                end else begin
                    byte_cnt <= 5'd0;
                end
            end else begin
                case (state)
                    COLLECT: begin
                        if (axiiv) begin
                            buf_bytes[5'd31 - byte_cnt] <= axiid;
                            byte_cnt <= byte_cnt + 5'd1;
                            if (last_byte) begin
                                fid     <= F_MDB;
                                gr      <= 1'b0;
                                ch      <= 1'b0;
                                bit_ptr <= 8'd0;
                                gap_cnt <= '0;
                            end
                        end
                    end
                    PARSE: begin
                        if (axiiv) overrun <= 1'b1;
                        if (step) begin
                            sh      <= sh_d;
                            fid     <= fid_d;
                            gr      <= gr_d;
                            ch      <= ch_d;
                            bit_ptr <= bit_ptr + 8'(width);
                            gap_cnt <= GAP_W'(PARSE_GAP);
                            if (parse_end) si <= sh_d;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        if (axiiv) overrun <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SIDE_INFO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            err_q <= 1'b0;
        end else if (state == PARSE && step && err_set) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_side_info_parser.sv
// tb/tb_side_info_parser.sv - scoreboard bench for side_info_parser
module tb_side_info_parser;
    import mp3_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       mono = 1'b0;
    logic [7:0] axiid = 8'd0;
    logic       axiiv = 1'b0;
    logic       busy, axiov, overrun, err;
    side_info_t si;

    side_info_parser #(.MAX_CH(2), .PARSE_GAP(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .mono        (mono),
        .axiid       (axiid),
        .axiiv       (axiiv),
        .busy        (busy),
        .axiov       (axiov),
        .overrun     (overrun),
        .err         (err),
        .si          (si)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int axiov_cnt = 0;
    int overrun_cnt = 0;
    side_info_t exp_q[$];
    logic [7:0] fb [32];
    int flen;
    logic [255:0] enc_bits;
    int enc_pos;

    always @(negedge clk) begin
        if (axiov === 1'b1) axiov_cnt++;
        if (overrun === 1'b1) overrun_cnt++;
    end

    task automatic put(input logic [11:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            enc_bits[255 - enc_pos] = v[i];
            enc_pos++;
        end
    endtask

    task automatic build_frame(input side_info_t s, input bit single);
        gr_ch_t g;
        int nch;
        nch = single ? 1 : 2;
        enc_bits = '0;
        enc_pos = 0;
        put(12'(s.main_data_begin), 9);
        put(12'(s.private_bits), single ? 5 : 3);
        for (int c = 0; c < nch; c++) put(12'(s.scfsi[c]), 4);
        for (int gi = 0; gi < 2; gi++) begin
            for (int c = 0; c < nch; c++) begin
                g = s.gc[gi][c];
                put(g.part2_3_length, 12);
                put(12'(g.big_values), 9);
                put(12'(g.global_gain), 8);
                put(12'(g.scalefac_compress), 4);
                put(12'(g.window_switching_flag), 1);
                if (g.window_switching_flag) begin
                    put(12'(g.block_type), 2);
                    put(12'(g.mixed_block_flag), 1);
                    put(12'(g.table_select[0]), 5);
                    put(12'(g.table_select[1]), 5);
                    for (int k = 0; k < 3; k++) put(12'(g.subblock_gain[k]), 3);
                end else begin
                    for (int k = 0; k < 3; k++) put(12'(g.table_select[k]), 5);
                    put(12'(g.region0_count), 4);
                    put(12'(g.region1_count), 3);
                end
                put(12'(g.preflag), 1);
                put(12'(g.scalefac_scale), 1);
                put(12'(g.count1table_select), 1);
            end
        end
        for (int k = 0; k < 32; k++) fb[k] = enc_bits[255 - 8*k -: 8];
        flen = single ? 17 : 32;
    endtask

    // Random side info already in decoded form (implicit fields filled by rule).
    function automatic side_info_t rand_si(input bit single);
        side_info_t s;
        gr_ch_t g;
        int nch;
        nch = single ? 1 : 2;
        s = '0;
        s.main_data_begin = 9'($urandom);
        s.private_bits = single ? 5'($urandom) : 5'($urandom_range(0, 7));
        for (int c = 0; c < nch; c++) s.scfsi[c] = 4'($urandom);
        for (int gi = 0; gi < 2; gi++) begin
            for (int c = 0; c < nch; c++) begin
                g = '0;
                g.part2_3_length = 12'($urandom);
                g.big_values = 9'($urandom);
                g.global_gain = 8'($urandom);
                g.scalefac_compress = 4'($urandom);
                g.window_switching_flag = 1'($urandom);
                g.table_select[0] = 5'($urandom);
                g.table_select[1] = 5'($urandom);
                g.preflag = 1'($urandom);
                g.scalefac_scale = 1'($urandom);
                g.count1table_select = 1'($urandom);
                if (g.window_switching_flag) begin
                    g.block_type = 2'($urandom_range(1, 3));
                    g.mixed_block_flag = 1'($urandom);
                    for (int k = 0; k < 3; k++) g.subblock_gain[k] = 3'($urandom);
                    if (g.block_type == 2'd2 && !g.mixed_block_flag) begin
                        g.region0_count = 4'd8;
                        g.region1_count = 4'd12;
                    end else begin
                        g.region0_count = 4'd7;
                        g.region1_count = 4'd13;
                    end
                end else begin
                    g.table_select[2] = 5'($urandom);
                    g.region0_count = 4'($urandom);
                    g.region1_count = 4'($urandom_range(0, 7));
                end
                s.gc[gi][c] = g;
            end
        end
        return s;
    endfunction

    task automatic drive_frame(input bit mono_in, input bit fs_with_byte, input int nbytes);
        int k;
        k = 0;
        frame_start = 1'b1;
        mono = mono_in;
        if (fs_with_byte) begin
            axiiv = 1'b1;
            axiid = fb[0];
            k = 1;
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        mono = 1'b0;
        axiiv = 1'b0;
        while (k < nbytes) begin
            axiiv = 1'b1;
            axiid = fb[k];
            k++;
            @(posedge clk); #1;
        end
        axiiv = 1'b0;
    endtask

    // Waits (bounded) for axiov, then pops the scoreboard and compares si.
    task automatic expect_frame(input string name);
        side_info_t e;
        int n;
        n = 0;
        while (axiov !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty axiov=%b", name, axiov);
        end else begin
            e = exp_q.pop_front();
            if (axiov !== 1'b1) begin
                errors++;
                $display("FAIL %s_axiov_timeout got axiov=%b required 1", name, axiov);
            end else if (si !== e) begin
                errors++;
                $display("FAIL %s_si got %h required %h", name, si, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (axiov !== 1'b0)   begin errors++; $display("FAIL reset_axiov got %b required 0", axiov); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b required 0", overrun); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b required 0", err); end
        checks++; if (si !== '0)        begin errors++; $display("FAIL reset_si got %h required 0", si); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_stereo;
        int a0;
        a0 = axiov_cnt;
        for (int k = 0; k < 32; k++) fb[k] = 8'h00;
        exp_q.push_back('0);
        drive_frame(1'b0, 1'b0, 32);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_parse got %b required 1", busy); end
        expect_frame("zero_stereo");
        checks++; if (axiov_cnt - a0 !== 1) begin errors++; $display("FAIL zero_axiov_count got %0d required 1", axiov_cnt - a0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err got %b required 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b required 0", busy); end
    endtask

    task automatic test_random_frames;
        side_info_t s;
        bit m;
        for (int i = 0; i < 6; i++) begin
            m = (i % 3 == 2);
            s = rand_si(m);
            build_frame(s, m);
            exp_q.push_back(s);
            drive_frame(m, (i % 2 == 1), flen);
            expect_frame($sformatf("random%0d", i));
        end
    endtask

    task automatic test_mono_pattern;
        side_info_t e;
        int a0;
        e = '0;
        e.main_data_begin = 9'h1FF;
        fb[0] = 8'hFF;
        fb[1] = 8'h80;
        for (int k = 2; k < 32; k++) fb[k] = 8'h00;
        exp_q.push_back(e);
        a0 = axiov_cnt;
        drive_frame(1'b1, 1'b0, 17);
        checks++; if (axiov_cnt !== a0) begin errors++; $display("FAIL mono_early_axiov got %0d required %0d", axiov_cnt, a0); end
        expect_frame("mono_pattern");
        checks++; if (si.main_data_begin !== 9'h1FF) begin errors++; $display("FAIL mono_mdb got %h required 1ff", si.main_data_begin); end
        checks++; if (si.private_bits !== 5'd0) begin errors++; $display("FAIL mono_priv got %h required 0", si.private_bits); end
        checks++; if (si.gc[0][1] !== '0 || si.gc[1][1] !== '0 || si.scfsi[1] !== 4'd0) begin
            errors++; $display("FAIL mono_ch1 got %h/%h/%h required 0", si.gc[0][1], si.gc[1][1], si.scfsi[1]);
        end
    endtask

    task automatic test_short_block;
        side_info_t s;
        gr_ch_t g;
        s = rand_si(1'b0);
        g = s.gc[0][0];
        g.window_switching_flag = 1'b1;
        g.block_type = 2'd2;
        g.mixed_block_flag = 1'b0;
        g.table_select[2] = 5'd0;
        g.subblock_gain[0] = 3'd5;
        g.region0_count = 4'd8;
        g.region1_count = 4'd12;
        s.gc[0][0] = g;
        build_frame(s, 1'b0);
        exp_q.push_back(s);
        drive_frame(1'b0, 1'b0, 32);
        expect_frame("short_block");
        checks++; if (si.gc[0][0].region0_count !== 4'd8) begin errors++; $display("FAIL short_region0 got %0d required 8", si.gc[0][0].region0_count); end
        checks++; if (si.gc[0][0].region1_count !== 4'd12) begin errors++; $display("FAIL short_region1 got %0d required 12", si.gc[0][0].region1_count); end
        checks++; if (si.gc[0][0].table_select[2] !== 5'd0) begin errors++; $display("FAIL short_ts2 got %0d required 0", si.gc[0][0].table_select[2]); end
    endtask

    task automatic test_overrun;
        side_info_t s;
        int o0;
        s = rand_si(1'b0);
        build_frame(s, 1'b0);
        exp_q.push_back(s);
        o0 = overrun_cnt;
        drive_frame(1'b0, 1'b0, 32);
        axiiv = 1'b1;
        axiid = 8'hA5;
        @(posedge clk); #1;
        axiiv = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %b required 1", overrun); end
        @(posedge clk); #1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b required 0", overrun); end
        expect_frame("overrun_frame");
        checks++; if (overrun_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_count got %0d required 1", overrun_cnt - o0); end
    endtask

    task automatic test_reset_midframe;
        side_info_t s;
        int a0;
        s = rand_si(1'b0);
        build_frame(s, 1'b0);
        a0 = axiov_cnt;
        drive_frame(1'b0, 1'b0, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
        checks++; if (si !== '0) begin errors++; $display("FAIL rstmid_si got %h required 0", si); end
        s = rand_si(1'b0);
        build_frame(s, 1'b0);
        exp_q.push_back(s);
        drive_frame(1'b0, 1'b0, 32);
        expect_frame("rstmid_frame");
        repeat (5) @(posedge clk);
        #1;
        checks++; if (axiov_cnt - a0 !== 1) begin errors++; $display("FAIL rstmid_axiov_count got %0d required 1", axiov_cnt - a0); end
    endtask

    task automatic test_abort;
        side_info_t s;
        int a0;
        a0 = axiov_cnt;
        s = rand_si(1'b0);
        build_frame(s, 1'b0);
        drive_frame(1'b0, 1'b0, 32);
        repeat (5) @(posedge clk);
        #1;
        s = rand_si(1'b0);
        build_frame(s, 1'b0);
        exp_q.push_back(s);
        drive_frame(1'b0, 1'b1, 32);
        expect_frame("abort_second");
        checks++; if (axiov_cnt - a0 !== 1) begin errors++; $display("FAIL abort_axiov_count got %0d required 1", axiov_cnt - a0); end
    endtask

    task automatic test_idle_bytes;
        int o0;
        o0 = overrun_cnt;
        for (int k = 0; k < 3; k++) begin
            axiiv = 1'b1;
            axiid = 8'(k + 1);
            @(posedge clk); #1;
        end
        axiiv = 1'b0;
        @(posedge clk); #1;
        checks++; if (overrun_cnt !== o0) begin errors++; $display("FAIL idle_overrun got %0d required %0d", overrun_cnt, o0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b required 0", busy); end
    endtask

    task automatic test_err;
        side_info_t s;
        gr_ch_t g;
        s = rand_si(1'b0);
        g = s.gc[0][0];
        g.window_switching_flag = 1'b1;
        g.block_type = 2'd0;
        g.table_select[2] = 5'd0;
        g.region0_count = 4'd7;
        g.region1_count = 4'd13;
        s.gc[0][0] = g;
        build_frame(s, 1'b0);
        exp_q.push_back(s);
        drive_frame(1'b0, 1'b0, 32);
        expect_frame("err_frame");
`ifdef SIDE_INFO_CHECK_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b required 1", err); end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b required 0", err); end
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_disabled got %b required 0", err); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_stereo();
        test_random_frames();
        test_mono_pattern();
        test_short_block();
        test_overrun();
        test_reset_midframe();
        test_abort();
        test_idle_bytes();
        test_random_frames();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/side_info_parser.md
SIDE_INFO_PARSER -- requirements
Module: side_info_parser

Interface
REQ-001 SHALL have parameter MAX_CH, default 2, maximum channels decoded (1 or 2).
REQ-002 SHALL have parameter PARSE_GAP, default 0, idle cycles inserted between extracted fields (throughput throttle).
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frame_start  input  1  pulse, restarts byte collection for a new frame.
REQ-006 SHALL have port mono  input  1  channel_mode==3, sampled on frame_start.
REQ-007 SHALL have port axiid  input  8  side-info byte, MSB first.
REQ-008 SHALL have port axiiv  input  1  axiid valid.
REQ-009 SHALL have port busy  output  1  high while collecting or parsing.
REQ-010 SHALL have port axiov  output  1  one-cycle pulse, si complete and valid.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse, byte dropped.
REQ-012 SHALL have port err  output  1  sticky reserved-field flag (see Configuration).
REQ-013 SHALL have port si  output  side_info_t  all decoded side-info fields, both granules, two channel slots.

Function
REQ-014 SHALL use states IDLE, COLLECT, PARSE, DONE; frame_start from any state -> COLLECT, byte count 0, mono latched.
REQ-015 SHALL in COLLECT store each axiiv byte into a 256-bit buffer; frame length 17 bytes if mono or MAX_CH==1, else 32.
REQ-016 SHALL on the accepted final byte move to PARSE on the next cycle; axiiv bytes in IDLE are dropped without overrun.
REQ-017 SHALL in PARSE walk fields in ISO 11172-3 order using a bit pointer, one field per (1+PARSE_GAP) cycles.
REQ-018 SHALL decode main_data_begin 9 b; private_bits 5 b mono / 3 b stereo; scfsi 4 b per channel.
REQ-019 SHALL per granule/channel decode part2_3_length 12, big_values 9, global_gain 8, scalefac_compress 4, window_switching_flag 1.
REQ-020 SHALL if window_switching_flag: block_type 2, mixed_block_flag 1, table_select[0..1] 5 each, subblock_gain[0..2] 3 each; table_select[2]=0; region0/region1 = 8/12 if block_type==2 and !mixed, else 7/13.
REQ-021 SHALL if !window_switching_flag: table_select[0..2] 5 each, region0_count 4, region1_count 3, block_type=0, mixed_block_flag=0, subblock_gain=0.
REQ-022 SHALL then decode preflag, scalefac_scale, count1table_select 1 b each.
REQ-023 SHALL in mono frames write channel-1 fields of si to 0.
REQ-024 SHALL update si only when axiov pulses (shadow registers during PARSE); si holds between frames.
REQ-025 SHALL assert axiov in DONE for exactly one cycle, then return to IDLE; busy low in DONE.
REQ-026 SHALL on axiiv during PARSE/DONE drop the byte and pulse overrun the next cycle; current parse unaffected.
REQ-027 SHALL on frame_start during PARSE abort the parse, suppress axiov, leave si unchanged.
REQ-028 SHALL on frame_start and axiiv in the same cycle accept that byte as byte 0 of the new frame.

Reset
REQ-029 SHALL on rst clear state to IDLE, byte count, bit pointer, buffer, busy, axiov, overrun, err and all si fields to 0.
REQ-030 SHALL give rst priority over frame_start and axiiv; rst mid-frame discards the partial frame.

Configuration
REQ-031 SHALL with SIDE_INFO_CHECK_EN defined set err when window_switching_flag==1 and block_type==0, cleared only by rst or frame_start.
REQ-032 SHALL without SIDE_INFO_CHECK_EN tie err to 0 and omit the check logic.

Structure
REQ-033 SHALL take side_info_t, field widths, frame lengths (17/32) and region defaults (7,8,12,13) from package mp3_pkg.
REQ-034 SHALL use sub-module bit_extractor: buffer, bit pointer, width (1..12) in; right-aligned field out, combinational.

Verification
REQ-035 SHALL cover: stereo, 32 bytes of 0x00 -> one axiov, all si fields 0, err 0.
REQ-036 SHALL cover: mono, bytes 0xFF,0x80 then 15x0x00 -> axiov after byte 17, main_data_begin 0x1FF, private_bits 0, channel-1 fields 0.
REQ-037 SHALL cover: stereo, gr0/ch0 window_switching_flag=1, block_type=2, mixed=0 -> region0_count 8, region1_count 12, table_select[2] 0.
REQ-038 SHALL cover: 33rd byte during PARSE -> overrun single pulse, si of the in-flight frame still correct.
REQ-039 SHALL cover: rst after byte 10, then full stereo frame -> exactly one axiov, fields from the second frame only.
REQ-040 SHALL cover: SIDE_INFO_CHECK_EN defined, window_switching_flag=1 with block_type 0 -> err 1 until next frame_start.
